// File: rtl/conv_pixel_engine.sv
// ============================================================================
//  Module      : conv_pixel_engine
//  Description : int8 MAC engine producing one leaky-ReLU, requantized int8
//                output per MACS weight/activation pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_pixel_engine #(
    parameter int MACS    = 576,
    parameter int SCALE_Q = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] bias,
    input  logic        [15:0] scale,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  weight,
    input  logic signed [7:0]  activation,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  out_int8,
    output logic signed [31:0] out_acc,
    output logic               busy
);

    localparam int CNT_W = $clog2(MACS + 1);
    localparam logic signed [47:0] c_half = 48'sd1 <<< (SCALE_Q - 1);
    localparam logic signed [47:0] c_max  = 48'sd127;
    localparam logic signed [47:0] c_min  = -48'sd128;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_ACT  = 3'd2,
        S_REQ  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic signed [31:0]  r_acc;
    logic signed [31:0]  r_bias;
    logic        [15:0]  r_scale;
    logic signed [31:0]  r_y;

    logic                w_accept;
    logic                w_last;
    logic signed [15:0]  w_prod;
    logic signed [31:0]  w_sum;
    logic signed [31:0]  w_leaky;
    logic signed [47:0]  w_y48;
    logic signed [47:0]  w_scale48;
    logic signed [47:0]  w_p;
    logic signed [47:0]  w_r;
    logic signed [7:0]   w_sat;

    assign w_accept  = (r_state == S_MAC) && in_valid;
    assign w_last    = (r_cnt == CNT_W'(MACS - 1));
    assign w_prod    = weight * activation;
    assign w_sum     = r_acc + r_bias;
    assign w_leaky   = w_sum[31] ? (w_sum >>> 3) : w_sum;

    // Scale is unsigned, so it is zero-extended before the signed multiply.
    assign w_y48     = {{16{r_y[31]}}, r_y};
    assign w_scale48 = {32'd0, r_scale};
    assign w_p       = w_y48 * w_scale48;
    assign w_r       = (w_p + c_half) >>> SCALE_Q;

    always_comb begin
        w_sat = w_r[7:0];
        if (w_r > c_max) begin
            w_sat = 8'sd127;
        end else if (w_r < c_min) begin
            w_sat = -8'sd128;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MAC;
            S_MAC:   if (w_accept && w_last) w_next = S_ACT;
            S_ACT:   w_next = S_REQ;
            S_REQ:   w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_bias   <= '0;
            r_scale  <= '0;
            r_y      <= '0;
            out_acc  <= '0;
            out_int8 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bias  <= bias;
                        r_scale <= scale;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_MAC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + {{16{w_prod[15]}}, w_prod};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    out_acc <= w_sum;
                    r_y     <= w_leaky;
                end
                S_REQ: begin
                    out_int8 <= w_sat;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_MAC);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_pixel_engine.sv
// ============================================================================
//  Module      : tb_conv_pixel_engine
//  Description : Self-checking bench for conv_pixel_engine (MACS=4, 1, 576).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_pixel_engine;

    typedef struct { int acc; int i8; } exp_t;
    typedef struct {
        int d; int n; int w[4]; int a[4]; int b; int s; int eacc; int ei8;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic               out_ready;
    logic signed [31:0] bias;
    logic        [15:0] scale;
    logic signed [7:0]  weight;
    logic signed [7:0]  activation;
    logic               start_v     [3];
    logic               in_ready_v  [3];
    logic               out_valid_v [3];
    logic               busy_v      [3];
    logic signed [7:0]  out_int8_v  [3];
    logic signed [31:0] out_acc_v   [3];

    int   errors = 0;
    int   checks = 0;
    int   wv [576];
    int   av [576];
    int   n_results [3] = '{0, 0, 0};
    exp_t sbq [$];
    vec_t vt [10];

    conv_pixel_engine #(.MACS(4), .SCALE_Q(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .weight(weight),
        .activation(activation), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_int8(out_int8_v[0]), .out_acc(out_acc_v[0]), .busy(busy_v[0]));

    conv_pixel_engine #(.MACS(1), .SCALE_Q(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .weight(weight),
        .activation(activation), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_int8(out_int8_v[1]), .out_acc(out_acc_v[1]), .busy(busy_v[1]));

    conv_pixel_engine #(.MACS(576), .SCALE_Q(16)) u_dut576 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bias(bias), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready_v[2]), .weight(weight),
        .activation(activation), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_int8(out_int8_v[2]), .out_acc(out_acc_v[2]), .busy(busy_v[2]));

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (out_valid_v[d] && out_ready) n_results[d] <= n_results[d] + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 32-bit wrapping sum, leaky ReLU by /8 (floor), Q16 round-half-up.
    function automatic exp_t model(input int n, input int b, input int s);
        exp_t   e;
        int     acc;
        int     y;
        longint p;
        longint r;
        acc = 0;
        for (int i = 0; i < n; i++) acc += wv[i] * av[i];
        acc = acc + b;
        y = (acc < 0) ? (acc >>> 3) : acc;
        p = longint'(y) * longint'(s);
        r = (p + 64'sd32768) >>> 16;
        e.acc = acc;
        e.i8  = (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
        return e;
    endfunction

    task automatic run_op(input int d, input int n, input int b, input int s,
                          input int gap_pct, input int hold, input exp_t e_in);
        exp_t e;
        int   k;
        int   early;
        int   ready_bad;
        int   held_bad;
        int   res0;
        early = 0; ready_bad = 0; held_bad = 0;
        sbq.push_back(e_in);
        // A pair alongside start arrives while IDLE and must be dropped.
        bias = b; scale = 16'(s); start_v[d] = 1'b1;
        in_valid = 1'b1; weight = 8'sd99; activation = 8'sd99;
        tick();
        start_v[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    early |= int'(out_valid_v[d]);
                end
            end
            in_valid = 1'b1; weight = 8'(wv[i]); activation = 8'(av[i]);
            ready_bad |= int'(!in_ready_v[d]);
            tick();
            early |= int'(out_valid_v[d]);
        end
        in_valid = 1'b0;
        k = 0;
        while (!out_valid_v[d] && k < 10) begin
            tick();
            k++;
        end
        chk("latency", k, 2);
        chk("in_ready_mac", ready_bad, 0);
        chk("no_early_valid", early, 0);
        e = sbq.pop_front();
        chk("out_acc", out_acc_v[d], e.acc);
        chk("out_int8", out_int8_v[d], e.i8);
        chk("in_ready_out", in_ready_v[d], 0);
        res0 = n_results[d];
        for (int h = 0; h < hold; h++) begin
            start_v[d] = (h == 1);
            in_valid = 1'b1; weight = 8'sd77; activation = 8'sd77;
            tick();
            if (!out_valid_v[d] || out_acc_v[d] !== e.acc || out_int8_v[d] !== 8'(e.i8))
                held_bad = 1;
        end
        if (hold > 0) chk("held_outputs", held_bad, 0);
        in_valid = 1'b0;
        // Start on the completing edge must also be ignored.
        out_ready = 1'b1; start_v[d] = 1'b1;
        tick();
        out_ready = 1'b0; start_v[d] = 1'b0;
        chk("out_valid_clear", out_valid_v[d], 0);
        chk("busy_after_out", busy_v[d], 0);
        repeat (3) tick();
        chk("one_result", n_results[d] - res0, 1);
    endtask

    initial begin
        exp_t e;
        int   b;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        bias = '0; scale = '0; weight = '0; activation = '0;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", busy_v[d], 0);
            chk("rst_in_ready", in_ready_v[d], 0);
            chk("rst_out_valid", out_valid_v[d], 0);
            chk("rst_out_int8", out_int8_v[d], 0);
            chk("rst_out_acc", out_acc_v[d], 0);
        end

        vt[0] = '{0, 4, '{1, 2, 3, 4},         '{1, 1, 1, 1},         0,            32768, 10,          5};
        vt[1] = '{0, 4, '{-1, -2, -3, -4},     '{1, 1, 1, 1},         0,            32768, -10,         -1};
        vt[2] = '{0, 4, '{10, 20, 30, 40},     '{2, 2, 2, 2},         100,          65535, 300,         127};
        vt[3] = '{0, 4, '{127, 127, 127, 127}, '{-128, -128, -128, -128}, 65024,    65535, 0,           0};
        vt[4] = '{0, 4, '{3, 0, 0, 0},         '{5, 5, 5, 5},         -20,          65535, -5,          -1};
        vt[5] = '{0, 4, '{127, 127, 127, 127}, '{127, 127, 127, 127}, 32'h7FFFFFFF, 655,   -2147419133, -128};
        vt[6] = '{0, 4, '{1, 2, 3, 4},         '{1, 1, 1, 1},         0,            0,     10,          0};
        vt[7] = '{0, 4, '{1, 0, 0, 0},         '{1, 1, 1, 1},         0,            32768, 1,           1};
        vt[8] = '{0, 4, '{-8, 0, 0, 0},        '{1, 1, 1, 1},         0,            32768, -8,          0};
        vt[9] = '{1, 1, '{127, 0, 0, 0},       '{127, 0, 0, 0},       0,            65535, 16129,       127};
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 4; i++) begin
                wv[i] = vt[t].w[i];
                av[i] = vt[t].a[i];
            end
            run_op(vt[t].d, vt[t].n, vt[t].b, vt[t].s, (t % 2) * 40, 0,
                   '{vt[t].eacc, vt[t].ei8});
        end

        // Full-length negative saturation.
        for (int i = 0; i < 576; i++) begin wv[i] = -128; av[i] = 127; end
        run_op(2, 576, 0, 655, 0, 0, '{-9363456, -128});

        // Input gaps plus output backpressure with start pulses during OUT.
        for (int i = 0; i < 576; i++) begin
            wv[i] = int'($urandom_range(0, 40)) - 20;
            av[i] = int'($urandom_range(0, 15));
        end
        run_op(2, 576, 123, 655, 40, 5, model(576, 123, 655));

        // Reset part-way through accumulation.
        start_v[2] = 1'b1; bias = 32'sd5000; scale = 16'd655;
        tick();
        start_v[2] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; weight = 8'sd100; activation = 8'sd100;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_busy", busy_v[2], 0);
        chk("midrst_in_ready", in_ready_v[2], 0);
        chk("midrst_out_valid", out_valid_v[2], 0);
        chk("midrst_out_acc", out_acc_v[2], 0);
        chk("midrst_out_int8", out_int8_v[2], 0);
        repeat (2) tick();
        run_op(2, 576, 123, 655, 10, 0, model(576, 123, 655));

        // Four regression channels with independent data and bias.
        for (int ch = 0; ch < 4; ch++) begin
            for (int i = 0; i < 576; i++) begin
                wv[i] = int'($urandom_range(0, 40)) - 20;
                av[i] = int'($urandom_range(0, 15));
            end
            b = int'($urandom_range(0, 4000)) - 2000;
            e = model(576, b, 655);
            run_op(2, 576, b, 655, 15, 0, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_pixel_engine.md
CONV_PIXEL_ENGINE -- requirements
Module: conv_pixel_engine

Interface
REQ-001 The block SHALL have parameter MACS, default 576, giving the number of weight/activation pairs per output (64 ch x 3x3).
REQ-002 The block SHALL have parameter SCALE_Q, default 16, giving the fractional bits of scale.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin one output pixel/channel.
REQ-006 The block SHALL have port bias, input, 32 bits, signed: added to the accumulator; latched at start.
REQ-007 The block SHALL have port scale, input, 16 bits, unsigned Q0.SCALE_Q: requantize multiplier; latched at start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: weight/activation pair valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts a pair.
REQ-010 The block SHALL have port weight, input, 8 bits, signed int8.
REQ-011 The block SHALL have port activation, input, 8 bits, signed int8.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-014 The block SHALL have port out_int8, output, 8 bits, signed: requantized result.
REQ-015 The block SHALL have port out_acc, output, 32 bits, signed: acc+bias before activation, for debug.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL have states IDLE, MAC, ACT, REQ and OUT.
REQ-018 IDLE: start=1 SHALL latch bias and scale, clear acc and cnt, and move to MAC. start in any other state SHALL be ignored.
REQ-019 MAC: in_ready SHALL be 1. Each in_valid&in_ready edge SHALL do acc <= acc + sext32(weight*activation) (16-bit signed product) and cnt <= cnt+1. in_valid gaps SHALL NOT change the result.
REQ-020 The edge accepting pair number MACS (cnt==MACS-1) SHALL move the state to ACT.
REQ-021 ACT: sum = acc + bias_l, 32-bit two's-complement wrap. The block SHALL register out_acc <= sum and y <= (sum>=0 ? sum : sum>>>3), arithmetic shift, then move to REQ.
REQ-022 REQ: p = y*scale_l as a 48-bit signed product; r = (p + 2^(SCALE_Q-1)) >>> SCALE_Q. The block SHALL register out_int8 <= saturate r to [-128,127], set out_valid, and move to OUT.
REQ-023 Latency: out_valid SHALL rise on the 2nd rising edge after the edge that accepts the final pair.
REQ-024 OUT: out_valid, out_int8 and out_acc SHALL stay stable until out_valid&out_ready; that edge SHALL clear out_valid and return to IDLE. in_ready SHALL be 0 in OUT.
REQ-025 in_ready SHALL be 0 in IDLE, ACT, REQ and OUT. A pair presented outside MAC SHALL be dropped without effect.
REQ-026 A start presented on the same edge that OUT completes SHALL be ignored; start is recognised only while in IDLE.
REQ-027 cnt SHALL be clog2(MACS+1) bits wide and SHALL never wrap within an operation.

Reset
REQ-028 rst=1 at any edge, including mid-MAC or in OUT, SHALL force IDLE, in_ready=0, out_valid=0, busy=0, out_int8=0, out_acc=0, and acc, cnt, bias_l and scale_l all to 0.
REQ-029 The first start after reset SHALL produce a result independent of any pre-reset partial accumulation.

Verification
REQ-030 Basic: MACS=4, w={1,2,3,4}, a={1,1,1,1}, bias=0, scale=32768 -> out_acc=10, out_int8=5.
REQ-031 Negative saturation: MACS=576, all w=-128, all a=127, bias=0, scale=655 -> out_acc=-9363456, leaky=-1170432, out_int8=-128.
REQ-032 Positive saturation: MACS=1, w=127, a=127, bias=0, scale=65535 -> out_acc=16129, out_int8=127.
REQ-033 Stalls and backpressure: random in_valid gaps, then out_ready low for 5 cycles with start pulsed during OUT -> same result as without stalls; outputs held; start ignored; exactly one result.
REQ-034 Reset mid-MAC: rst after 100 of 576 pairs, then a new start with a full stream -> result equals a fresh run; out_valid stays 0 until the new result.
REQ-035 Golden regression: 4 channels of 576 pairs plus bias from the Python-generated hex files, scale=655 -> out_int8 matches the expected hex for each channel.
